fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of decode; drives the 16-bit instruction read port of the 1 kB unified memory and consumes its parcel output.
- Fetches one 16-bit parcel per cycle into a small prefetch queue.
- Assembles 16- or 32-bit instructions from the parcels and presents them to decode with a valid/ready handshake.
- Supports a branch/jump redirect that flushes the queue.

---
 rtl/fetch_unit.sv | 86 ++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: streams 16-bit parcels into a small circular queue
// and assembles 16/32-bit instructions for decode behind a valid/ready handshake.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [30:0] rd0_addr,
    input  logic [15:0] rd0_data,
    input  logic        redirect_en,
    input  logic [30:0] redirect_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_len32,
    output logic [30:0] out_pc
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   q_data [DEPTH];
    logic [30:0]   q_pc   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_nx;
    logic [AW:0]   count;
    logic [30:0]   fetch_pc;
    logic          is32;
    logic          push;
    logic [1:0]    pop_n;

    assign rd0_addr = fetch_pc;
    assign head_nx  = head + AW'(1);

    // Length and validity come only from registered queue state.
    assign is32      = (q_data[head][15:14] == 2'b11);
    assign out_valid = is32 ? (count >= (AW+1)'(2))
                            : (count >= (AW+1)'(1));
    assign out_len32 = out_valid & is32;
    assign out_pc    = q_pc[head];

    always_comb begin
        out_inst = 32'h0;
        if (out_valid) begin
            if (is32) out_inst = {q_data[head], q_data[head_nx]};
            else      out_inst = {16'h0, q_data[head]};
        end
    end

    assign push = (count < (AW+1)'(DEPTH)) && !redirect_en;

    always_comb begin
        pop_n = 2'd0;
        if (out_valid && out_ready && !redirect_en)
            pop_n = is32 ? 2'd2 : 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC[31:1];
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= 16'h0;
                q_pc[i]   <= 31'h0;
            end
        end else if (redirect_en) begin
            fetch_pc <= redirect_addr;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                q_data[tail] <= rd0_data;
                q_pc[tail]   <= fetch_pc;
                tail         <= tail + AW'(1);
                fetch_pc     <= fetch_pc + 31'd1;
            end
            head  <= head + AW'(pop_n);
            count <= count + (AW+1)'(push) - (AW+1)'(pop_n);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected instructions into a
// scoreboard; a negedge monitor pops and compares on every accepted handshake.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [30:0] rd0_addr;
    logic [15:0] rd0_data;
    logic        redirect_en;
    logic [30:0] redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_len32;
    logic [30:0] out_pc;

    typedef struct {
        logic [31:0] inst;
        logic        len32;
        logic [30:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [512];
    int          total = 0;
    int          bad   = 0;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rd0_addr(rd0_addr),
        .rd0_data(rd0_data),
        .redirect_en(redirect_en),
        .redirect_addr(redirect_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst(out_inst),
        .out_len32(out_len32),
        .out_pc(out_pc)
    );

    assign rd0_data = mem[rd0_addr[8:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_en) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL accept: unexpected inst=%h pc=%h", out_inst, out_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_inst !== e.inst || out_len32 !== e.len32 || out_pc !== e.pc) begin
                    bad++;
                    $display("FAIL accept: got inst=%h len32=%b pc=%h want inst=%h len32=%b pc=%h",
                             out_inst, out_len32, out_pc, e.inst, e.len32, e.pc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_inst(input logic [31:0] inst, input logic len32, input logic [30:0] pc);
        exp_t e;
        e.inst  = inst;
        e.len32 = len32;
        e.pc    = pc;
        sb.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        out_ready     = 1'b0;
        redirect_en   = 1'b0;
        redirect_addr = 31'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Run until every expected instruction has been accepted, then stop accepting.
    task automatic drain(input bit toggle);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            out_ready = toggle ? ~out_ready : 1'b1;
            step();
            n++;
        end
        out_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: left=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        out_ready     = 1'b0;
        redirect_en   = 1'b0;
        redirect_addr = 31'h0;
        clear_mem();

        // two 16-bit parcels back to back
        mem[0] = 16'h1234;
        mem[1] = 16'h5678;
        do_reset();
        out_ready = 1'b1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_len32", 32'(out_len32), 32'h0);
        chk("rst_pc", 32'(out_pc), 32'h0);
        chk("rst_addr", 32'(rd0_addr), 32'h0);
        expect_inst(32'h0000_1234, 1'b0, 31'd0);
        expect_inst(32'h0000_5678, 1'b0, 31'd1);
        step();
        chk("t1_c1_valid", 32'(out_valid), 32'h1);
        chk("t1_c1_inst", out_inst, 32'h0000_1234);
        step();
        chk("t1_c2_inst", out_inst, 32'h0000_5678);
        chk("t1_c2_pc", 32'(out_pc), 32'h1);
        drain(1'b0);

        // 32-bit instruction needs both parcels
        clear_mem();
        mem[0] = 16'hC001;
        mem[1] = 16'hBEEF;
        mem[2] = 16'h1111;
        do_reset();
        out_ready = 1'b1;
        expect_inst(32'hC001_BEEF, 1'b1, 31'd0);
        expect_inst(32'h0000_1111, 1'b0, 31'd2);
        step();
        chk("t2_c1_valid", 32'(out_valid), 32'h0);
        step();
        chk("t2_c2_valid", 32'(out_valid), 32'h1);
        chk("t2_c2_inst", out_inst, 32'hC001_BEEF);
        chk("t2_c2_len32", 32'(out_len32), 32'h1);
        drain(1'b0);

        // full-queue stall
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 16'h0100 + 16'(i);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 4) chk("t3_mid_inst", out_inst, 32'h0000_0100);
        end
        chk("t3_addr", 32'(rd0_addr), 32'h4);
        chk("t3_valid", 32'(out_valid), 32'h1);
        chk("t3_inst", out_inst, 32'h0000_0100);
        for (int i = 0; i < 4; i++) expect_inst(32'h0000_0100 + 32'(i), 1'b0, 31'(i));
        drain(1'b0);

        // redirect with three parcels queued
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 16'h0200 + 16'(i);
        mem[9'h100] = 16'h0AAA;
        mem[9'h101] = 16'h0BBB;
        do_reset();
        step();
        step();
        step();
        chk("t4_pre_addr", 32'(rd0_addr), 32'h3);
        redirect_en   = 1'b1;
        redirect_addr = 31'h100;
        out_ready     = 1'b1;
        step();
        redirect_en = 1'b0;
        chk("t4_valid", 32'(out_valid), 32'h0);
        chk("t4_addr", 32'(rd0_addr), 32'h100);
        expect_inst(32'h0000_0AAA, 1'b0, 31'h100);
        expect_inst(32'h0000_0BBB, 1'b0, 31'h101);
        step();
        chk("t4_next_valid", 32'(out_valid), 32'h1);
        chk("t4_next_pc", 32'(out_pc), 32'h100);
        drain(1'b0);

        // mixed stream; the 32-bit instruction at pc 3 wraps slot 3 -> slot 0
        clear_mem();
        mem[0] = 16'h0011;
        mem[1] = 16'hC0AA;
        mem[2] = 16'h00BB;
        mem[3] = 16'hD00D;
        mem[4] = 16'hF00D;
        mem[5] = 16'h0055;
        mem[6] = 16'h0066;
        do_reset();
        expect_inst(32'h0000_0011, 1'b0, 31'd0);
        expect_inst(32'hC0AA_00BB, 1'b1, 31'd1);
        expect_inst(32'hD00D_F00D, 1'b1, 31'd3);
        expect_inst(32'h0000_0055, 1'b0, 31'd5);
        expect_inst(32'h0000_0066, 1'b0, 31'd6);
        drain(1'b1);

        // asynchronous reset in the middle of a cycle
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 16'h0300 + 16'(i);
        do_reset();
        step();
        step();
        step();
        chk("t6_pre_valid", 32'(out_valid), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_inst", out_inst, 32'h0);
        chk("t6_pc", 32'(out_pc), 32'h0);
        chk("t6_addr", 32'(rd0_addr), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
